counter_modn_ud: RTL and testbench

COUNTER_MODN_UD -- requirements
Module: counter_modn_ud

---
 rtl/counter_pkg.sv | 16 +
 rtl/counter_modn_ud.sv | 161 ++++++++++++++++
 tb/tb_counter_modn_ud.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-N up/down counter.
//   state_e      : one-shot sequencer states (IDLE, RUN, DONE)
//   MODE_FREE    : mode input value selecting free-running counting
//   MODE_ONESHOT : mode input value selecting start-triggered one-shot counting
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/counter_modn_ud.sv
// Modulo-N up/down counter with free-running and one-shot modes.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   en        : count enable
//   up_dn     : 1 = count up, 0 = count down
//   mode      : MODE_FREE / MODE_ONESHOT
//   start     : one-shot trigger (ignored in free-running mode)
//   clr       : synchronous clear (highest priority)
//   load      : synchronous load strobe
//   load_val  : value to load; values >= N saturate to N-1
//   data_out  : registered count
//   tc        : registered terminal-count pulse
//   done      : registered one-shot complete flag
//   load_err  : registered out-of-range load pulse
module counter_modn_ud
    import counter_pkg::*;
#(
    parameter int N      = 9,
    parameter int DWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up_dn,
    input  logic              mode,
    input  logic              start,
    input  logic              clr,
    input  logic              load,
    input  logic [DWIDTH-1:0] load_val,
    output logic [DWIDTH-1:0] data_out,
    output logic              tc,
    output logic              done,
    output logic              load_err
);

    // Wrap is detected by comparing against N-1 rather than adding and
    // reducing, so the arithmetic never needs a bit beyond DWIDTH and
    // N = 2**DWIDTH wraps naturally at all-ones.
    localparam logic [DWIDTH-1:0] MAX_VAL  = DWIDTH'(N - 32'sd1);
    localparam logic [DWIDTH-1:0] ZERO_VAL = DWIDTH'(1'b0);
    localparam logic [DWIDTH-1:0] ONE_VAL  = DWIDTH'(1'b1);

    logic [DWIDTH-1:0] cnt_q, cnt_d;
    logic              tc_q, tc_d;
    logic              done_q, done_d;
    logic              lerr_q, lerr_d;
    state_e            state_q, state_d;

    logic [DWIDTH-1:0] step_s;
    logic [DWIDTH-1:0] init_s;
    logic [DWIDTH-1:0] term_s;
    state_e            state_nx_s;
    logic              done_nx_s;

    // Direction-dependent next count, one-shot start value and terminal value.
    always_comb begin
        if (up_dn) begin
            step_s = (cnt_q == MAX_VAL) ? ZERO_VAL : (cnt_q + ONE_VAL);
            init_s = ZERO_VAL;
            term_s = MAX_VAL;
        end else begin
            step_s = (cnt_q == ZERO_VAL) ? MAX_VAL : (cnt_q - ONE_VAL);
            init_s = MAX_VAL;
            term_s = ZERO_VAL;
        end
    end

    // Next-state logic; priority is clr, load, start, then count.
    always_comb begin
        cnt_d      = cnt_q;
        state_nx_s = state_q;
        done_nx_s  = done_q;
        tc_d       = 1'b0;
        lerr_d     = 1'b0;
        if (clr) begin
            cnt_d      = ZERO_VAL;
            state_nx_s = IDLE;
            done_nx_s  = 1'b0;
        end else if (load) begin
            if (load_val > MAX_VAL) begin
                cnt_d  = MAX_VAL;
                lerr_d = 1'b1;
            end else begin
                cnt_d  = load_val;
            end
        end else if ((mode == MODE_ONESHOT) && start) begin
            // Start from any state (including RUN) restarts from the initial value.
            cnt_d      = init_s;
            state_nx_s = RUN;
            done_nx_s  = 1'b0;
        end else if (mode == MODE_FREE) begin
            if (en) begin
                cnt_d = step_s;
                tc_d  = (cnt_q == term_s);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (en) begin
                        // A direction change can leave the count already at the
                        // new terminal; finish there instead of wrapping past it.
                        if (cnt_q == term_s) begin
                            state_nx_s = DONE;
                            done_nx_s  = 1'b1;
                            tc_d       = 1'b1;
                        end else if (step_s == term_s) begin
                            cnt_d      = step_s;
                            state_nx_s = DONE;
                            done_nx_s  = 1'b1;
                            tc_d       = 1'b1;
                        end else begin
                            cnt_d      = step_s;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                IDLE:    state_nx_s = IDLE;
                DONE:    state_nx_s = DONE;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // Free-running mode always parks the sequencer; data_out is left untouched.
    always_comb begin
        if (mode == MODE_FREE) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end else begin
            state_d = state_nx_s;
            done_d  = done_nx_s;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= ZERO_VAL;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            lerr_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
            lerr_q  <= lerr_d;
            state_q <= state_d;
        end
    end

    assign data_out = cnt_q;
    assign tc       = tc_q;
    assign done     = done_q;
    assign load_err = lerr_q;

endmodule

// File: tb/tb_counter_modn_ud.sv
// Directed self-checking bench for counter_modn_ud with N=9, DWIDTH=4.
module tb_counter_modn_ud;

    logic       clk = 1'b1;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       mode;
    logic       start;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] data_out;
    logic       tc;
    logic       done;
    logic       load_err;

    int checks   = 0;
    int failures = 0;

    counter_modn_ud #(.N(9), .DWIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .mode     (mode),
        .start    (start),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .data_out (data_out),
        .tc       (tc),
        .done     (done),
        .load_err (load_err)
    );

    // Rising edges at 10, 20, 30 ns ...
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; up_dn = 1'b1; mode = 1'b0; start = 1'b0;
        clr = 1'b0; load = 1'b0; load_val = 4'd0;
        #1;
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_tc",   32'(tc),       32'd0);
        check("rst_done", 32'(done),     32'd0);
        check("rst_lerr", 32'(load_err), 32'd0);
        #14 rst = 1'b1;

        // Free-running up: 1..8 then 0, tc only after the 8->0 edge.
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("up_data", 32'(data_out), 32'(i % 9));
            check("up_tc",   32'(tc),       (i == 9) ? 32'd1 : 32'd0);
        end
        tick();
        check("up_after_wrap_data", 32'(data_out), 32'd1);
        check("up_after_wrap_tc",   32'(tc),       32'd0);

        // Free-running down from reset: 8,7,...,0,8; every 0->8 edge is a wrap.
        rst = 1'b0; up_dn = 1'b0;
        #1;
        check("dn_rst_data", 32'(data_out), 32'd0);
        #3 rst = 1'b1;
        for (int i = 0; i <= 9; i++) begin
            tick();
            check("dn_data", 32'(data_out), (i == 9) ? 32'd8 : 32'(8 - i));
            check("dn_tc",   32'(tc),       (i == 0 || i == 9) ? 32'd1 : 32'd0);
        end

        // Loads: in range, out of range (saturate + pulse), then pulse clears.
        en = 1'b0; load = 1'b1; load_val = 4'd5;
        tick();
        check("load5_data", 32'(data_out), 32'd5);
        check("load5_lerr", 32'(load_err), 32'd0);
        load_val = 4'd12;
        tick();
        check("load12_data", 32'(data_out), 32'd8);
        check("load12_lerr", 32'(load_err), 32'd1);
        load = 1'b0;
        tick();
        check("hold_data", 32'(data_out), 32'd8);
        check("hold_lerr", 32'(load_err), 32'd0);

        // One-shot up: start -> 0, then 1..8, done set with tc at 8.
        mode = 1'b1; up_dn = 1'b1; en = 1'b1; start = 1'b1;
        tick();
        check("os_start_data", 32'(data_out), 32'd0);
        check("os_start_done", 32'(done),     32'd0);
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("os_data", 32'(data_out), 32'(i));
            check("os_done", 32'(done),     (i == 8) ? 32'd1 : 32'd0);
            check("os_tc",   32'(tc),       (i == 8) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            check("os_hold_data", 32'(data_out), 32'd8);
            check("os_hold_done", 32'(done),     32'd1);
            check("os_hold_tc",   32'(tc),       32'd0);
        end
        start = 1'b1;
        tick();
        check("os_restart_data", 32'(data_out), 32'd0);
        check("os_restart_done", 32'(done),     32'd0);
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("os_rerun_data", 32'(data_out), 32'(i));
        end

        // clr and load together at count 4: clr wins, FSM back to IDLE.
        clr = 1'b1; load = 1'b1; load_val = 4'd7;
        tick();
        check("clr_data", 32'(data_out), 32'd0);
        check("clr_done", 32'(done),     32'd0);
        check("clr_lerr", 32'(load_err), 32'd0);
        clr = 1'b0; load = 1'b0;
        tick();
        check("idle_hold_data", 32'(data_out), 32'd0);

        // Async reset between edges at count 6.
        mode = 1'b0; load = 1'b1; load_val = 4'd5;
        tick();
        load = 1'b0;
        tick();
        check("pre_rst_data", 32'(data_out), 32'd6);
        #3 rst = 1'b0;
        #1;
        check("async_rst_data", 32'(data_out), 32'd0);
        tick();
        check("rst_held_data", 32'(data_out), 32'd0);
        rst = 1'b1;
        tick();
        check("post_rst_first", 32'(data_out), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
